// File: rtl/corner_tracker_pkg.sv
// Shared types and constants for the corner tracker: coordinate width,
// active-video limits, FSM state encoding, captured-corner and debug structs,
// plus small helpers for bounding-box span and midpoint.
package corner_tracker_pkg;

    localparam int COORD_W  = 10;
    localparam int MISS_W   = 4;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t H_MAX = coord_t'(H_ACTIVE - 1);
    localparam coord_t V_MAX = coord_t'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_FILTER  = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    typedef struct packed {
        coord_t tl_x;
        coord_t tl_y;
        coord_t tr_x;
        coord_t tr_y;
        coord_t bl_x;
        coord_t bl_y;
        coord_t br_x;
        coord_t br_y;
    } corners_t;

    typedef struct packed {
        state_t              state;
        corners_t            corners;
        logic [MISS_W-1:0]   miss_cnt;
    } dbg_t;

    // Width of the box along one axis; an inverted pair means nothing was seen.
    function automatic coord_t span_of(input coord_t lo, input coord_t hi);
        return (hi >= lo) ? coord_t'(hi - lo) : '0;
    endfunction

    // Midpoint with one extra bit so lo+hi never wraps.
    function automatic coord_t mid_of(input coord_t lo, input coord_t hi);
        logic [COORD_W:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[COORD_W:1];
    endfunction

endpackage

// File: rtl/corner_tracker_if.sv
// Result channel from the corner tracker to the servo/aim controller.
// Handshake: the master raises out_valid with stable data; a transfer happens
// on every clock edge where out_valid and out_ready are both high. Data and
// out_valid never change while out_valid=1 and out_ready=0, except when a new
// frame overwrites an unaccepted result, which is flagged by frame_overrun.
interface corner_tracker_if
    import corner_tracker_pkg::*;
();
    coord_t center_x;
    coord_t center_y;
    coord_t span_x;
    coord_t span_y;
    logic   target_lost;
    logic   out_valid;
    logic   out_ready;
    logic   frame_overrun;

    modport master (
        output center_x, center_y, span_x, span_y,
        output target_lost, out_valid, frame_overrun,
        input  out_ready
    );

    modport slave (
        input  center_x, center_y, span_x, span_y,
        input  target_lost, out_valid, frame_overrun,
        output out_ready
    );
endinterface

// File: rtl/corner_tracker_ema_axis.sv
// One axis of the centre filter: a shift-based exponential moving average
// with snap-to-raw and clamping to the axis limit.
// Optional macro CORNER_TRACKER_DEADBAND_EN: small moves (|raw-filt| within
// DEADBAND) leave the filter untouched to keep the servo from hunting.
module ema_axis
    import corner_tracker_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int DEADBAND    = 2
) (
    input  logic   clk,
    input  logic   reset_n,
    input  coord_t raw,
    input  logic   snap,
    input  logic   update,
    input  coord_t axis_max,
    output coord_t filt
);

`ifdef CORNER_TRACKER_DEADBAND_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    localparam logic [COORD_W:0] DB_LIM = (COORD_W+1)'(DEADBAND);

    coord_t                   filt_q;
    logic signed [COORD_W:0]  delta;
    logic signed [COORD_W:0]  step;
    logic signed [COORD_W+1:0] sum;
    logic [COORD_W:0]         mag;
    logic                     hold;
    coord_t                   snap_val;
    coord_t                   upd_val;

    // Signed step toward raw, deadband test and clamped candidate values.
    always_comb begin
        delta = $signed({1'b0, raw}) - $signed({1'b0, filt_q});
        step  = delta >>> ALPHA_SHIFT;
        sum   = $signed({2'b00, filt_q}) + $signed({step[COORD_W], step});
        mag   = delta[COORD_W] ? $unsigned(-delta) : $unsigned(delta);
        hold  = DB_ON & (mag <= DB_LIM);

        snap_val = (raw > axis_max) ? axis_max : raw;

        if (sum[COORD_W+1]) begin
            upd_val = '0;
        end else if (sum > $signed({2'b00, axis_max})) begin
            upd_val = axis_max;
        end else begin
            upd_val = sum[COORD_W-1:0];
        end
    end

    // Filter register: snap wins over a normal update; otherwise it holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
        end else if (snap) begin
            filt_q <= snap_val;
        end else if (update && !hold) begin
            filt_q <= upd_val;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/corner_tracker.sv
// Corner tracker: on each VGA_VS falling edge, captures the previous-frame
// corner coordinates, forms a bounding box, smooths its centre per axis,
// tracks target loss over empty frames and offers the result on a
// valid/ready channel. Pipeline: CAPTURE, COMPUTE, FILTER, then PRESENT.
// Optional macro CORNER_TRACKER_DEADBAND_EN enables the filter deadband
// inside ema_axis.
module corner_tracker
    import corner_tracker_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int LOST_FRAMES = 4,
    parameter int MIN_SPAN    = 4,
    parameter int DEADBAND    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             VGA_VS,
    input  coord_t           top_left_prev_x,
    input  coord_t           top_left_prev_y,
    input  coord_t           top_right_prev_x,
    input  coord_t           top_right_prev_y,
    input  coord_t           bot_left_prev_x,
    input  coord_t           bot_left_prev_y,
    input  coord_t           bot_right_prev_x,
    input  coord_t           bot_right_prev_y,
    corner_tracker_if.master res,
    output dbg_t             dbg
);

    localparam logic [MISS_W-1:0] LOST_LIM   = MISS_W'(LOST_FRAMES);
    localparam coord_t            MIN_SPAN_C = coord_t'(MIN_SPAN);

    logic              vs_prev;
    logic              vs_fall;
    state_t            state_q;
    state_t            state_d;
    logic              capture_en;
    logic              compute_en;
    logic              filter_en;
    logic              xfer;

    corners_t          corners_q;
    coord_t            span_x_w;
    coord_t            span_y_w;
    coord_t            cmp_span_x;
    coord_t            cmp_span_y;
    coord_t            cmp_raw_x;
    coord_t            cmp_raw_y;
    logic              cmp_empty;

    logic [MISS_W-1:0] miss_q;
    logic              lost_q;
    logic              snap_en;
    logic              upd_en;
    coord_t            filt_x;
    coord_t            filt_y;
    coord_t            span_x_q;
    coord_t            span_y_q;
    logic              out_valid_q;
    logic              overrun_q;

    assign vs_fall = vs_prev & ~VGA_VS;
    assign xfer    = out_valid_q & res.out_ready;

    // Previous VS sample for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vs_prev <= 1'b0;
        else          vs_prev <= VGA_VS;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: edges are only honoured in IDLE and PRESENT; an edge in
    // PRESENT starts the next frame whether or not the result was taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (vs_fall) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_COMPUTE;
            ST_COMPUTE: state_d = ST_FILTER;
            ST_FILTER:  state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (vs_fall)   state_d = ST_CAPTURE;
                else if (xfer) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: one enable per pipeline stage.
    always_comb begin
        capture_en = (state_q == ST_CAPTURE);
        compute_en = (state_q == ST_COMPUTE);
        filter_en  = (state_q == ST_FILTER);
    end

    // Corner capture; upstream registers are stable from the cycle after the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            corners_q <= '0;
        end else if (capture_en) begin
            corners_q <= '{tl_x: top_left_prev_x,  tl_y: top_left_prev_y,
                           tr_x: top_right_prev_x, tr_y: top_right_prev_y,
                           bl_x: bot_left_prev_x,  bl_y: bot_left_prev_y,
                           br_x: bot_right_prev_x, br_y: bot_right_prev_y};
        end
    end

    // Box extents: x from left/right-most pixels, y from top/bottom-most.
    always_comb begin
        span_x_w = span_of(corners_q.tl_x, corners_q.br_x);
        span_y_w = span_of(corners_q.tr_y, corners_q.bl_y);
    end

    // Bounding box centre, span and detection decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_span_x <= '0;
            cmp_span_y <= '0;
            cmp_raw_x  <= '0;
            cmp_raw_y  <= '0;
            cmp_empty  <= 1'b1;
        end else if (compute_en) begin
            cmp_span_x <= span_x_w;
            cmp_span_y <= span_y_w;
            cmp_raw_x  <= mid_of(corners_q.tl_x, corners_q.br_x);
            cmp_raw_y  <= mid_of(corners_q.tr_y, corners_q.bl_y);
            cmp_empty  <= (span_x_w < MIN_SPAN_C) || (span_y_w < MIN_SPAN_C);
        end
    end

    // A detection after loss jumps straight to the new position.
    assign snap_en = filter_en & ~cmp_empty & lost_q;
    assign upd_en  = filter_en & ~cmp_empty & ~lost_q;

    ema_axis #(.ALPHA_SHIFT(ALPHA_SHIFT), .DEADBAND(DEADBAND)) u_ema_x (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (cmp_raw_x),
        .snap     (snap_en),
        .update   (upd_en),
        .axis_max (H_MAX),
        .filt     (filt_x)
    );

    ema_axis #(.ALPHA_SHIFT(ALPHA_SHIFT), .DEADBAND(DEADBAND)) u_ema_y (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (cmp_raw_y),
        .snap     (snap_en),
        .update   (upd_en),
        .axis_max (V_MAX),
        .filt     (filt_y)
    );

    // Miss counter saturates at LOST_FRAMES; target_lost follows it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_q <= '0;
            lost_q <= 1'b1;
        end else if (filter_en) begin
            if (cmp_empty) begin
                if (miss_q < LOST_LIM) miss_q <= miss_q + 1'b1;
                if (miss_q >= LOST_LIM - 1'b1) lost_q <= 1'b1;
            end else begin
                miss_q <= '0;
                lost_q <= 1'b0;
            end
        end
    end

    // Result spans, valid flag and overrun pulse; new data lands on entry to PRESENT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            span_x_q    <= '0;
            span_y_q    <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= filter_en & out_valid_q & ~res.out_ready;
            if (filter_en) begin
                span_x_q    <= cmp_empty ? '0 : cmp_span_x;
                span_y_q    <= cmp_empty ? '0 : cmp_span_y;
                out_valid_q <= 1'b1;
            end else if (xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign res.center_x      = filt_x;
    assign res.center_y      = filt_y;
    assign res.span_x        = span_x_q;
    assign res.span_y        = span_y_q;
    assign res.target_lost   = lost_q;
    assign res.out_valid     = out_valid_q;
    assign res.frame_overrun = overrun_q;

    assign dbg = '{state: state_q, corners: corners_q, miss_cnt: miss_q};

endmodule

// File: tb/tb_corner_tracker.sv
// Bench for corner_tracker (default build, default parameters).
module tb_corner_tracker;
    import corner_tracker_pkg::*;

    localparam int RES_W = 4*COORD_W + 1;
    localparam int NV    = 16;

    typedef struct packed {
        coord_t cx;
        coord_t cy;
        coord_t sx;
        coord_t sy;
        logic   lost;
    } res_t;

    typedef struct {
        corners_t c;
        res_t     r;
    } vec_t;

    logic     clk     = 1'b0;
    logic     reset_n = 1'b0;
    logic     VGA_VS  = 1'b1;
    corners_t cin     = '0;
    dbg_t     dbg;
    bit       mon_en  = 1'b0;
    int       checks  = 0;
    int       errors  = 0;
    logic [RES_W-1:0] exp_q[$];
    vec_t     vecs[NV];

    corner_tracker_if res_if();

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    corner_tracker dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .VGA_VS           (VGA_VS),
        .top_left_prev_x  (cin.tl_x),
        .top_left_prev_y  (cin.tl_y),
        .top_right_prev_x (cin.tr_x),
        .top_right_prev_y (cin.tr_y),
        .bot_left_prev_x  (cin.bl_x),
        .bot_left_prev_y  (cin.bl_y),
        .bot_right_prev_x (cin.br_x),
        .bot_right_prev_y (cin.br_y),
        .res              (res_if),
        .dbg              (dbg)
    );

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic corners_t mk(input int tlx, input int tly, input int trx, input int tr_y,
                                    input int blx, input int bly, input int brx, input int bry);
        corners_t c;
        c.tl_x = coord_t'(tlx);  c.tl_y = coord_t'(tly);
        c.tr_x = coord_t'(trx);  c.tr_y = coord_t'(tr_y);
        c.bl_x = coord_t'(blx);  c.bl_y = coord_t'(bly);
        c.br_x = coord_t'(brx);  c.br_y = coord_t'(bry);
        return c;
    endfunction

    function automatic res_t rr(input int cx, input int cy, input int sx, input int sy, input bit lost);
        res_t r;
        r.cx = coord_t'(cx); r.cy = coord_t'(cy);
        r.sx = coord_t'(sx); r.sy = coord_t'(sy);
        r.lost = lost;
        return r;
    endfunction

    // Present corners and drop VS for one cycle; optionally raise out_ready
    // for exactly the edge cycle. Returns 1ns into the cycle after the edge.
    task automatic send_frame(input corners_t c, input bit rdy_pulse);
        @(posedge clk); #1;
        cin    = c;
        VGA_VS = 1'b0;
        if (rdy_pulse) res_if.out_ready = 1'b1;
        @(posedge clk); #1;
        VGA_VS = 1'b1;
        if (rdy_pulse) res_if.out_ready = 1'b0;
    endtask

    // Cycles (negedges) until out_valid is seen; 0 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_if.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        res_t e;
        if (mon_en && reset_n && res_if.out_valid && res_if.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected: got transfer cx=%0d, want none", res_if.center_x);
            end else begin
                e = exp_q.pop_front();
                check("xfer_center_x", res_if.center_x, e.cx);
                check("xfer_center_y", res_if.center_y, e.cy);
                check("xfer_span_x", res_if.span_x, e.sx);
                check("xfer_span_y", res_if.span_y, e.sy);
                check("xfer_target_lost", res_if.target_lost, e.lost);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        res_t d1, d2, d3, d4;
        corners_t f_a, f_b;

        // Stimulus table; expected values assume ALPHA_SHIFT=2, MIN_SPAN=4, LOST_FRAMES=4.
        vecs[0]  = '{mk(100,200, 120,180, 118,240, 140,210), rr(120,210, 40,60, 0)};
        vecs[1]  = '{mk(140,200, 160,180, 158,240, 180,210), rr(130,210, 40,60, 0)};
        vecs[2]  = '{mk(0,0, 0,0, 0,0, 0,0),                 rr(130,210,  0, 0, 0)};
        vecs[3]  = '{mk(0,0, 0,0, 0,0, 0,0),                 rr(130,210,  0, 0, 0)};
        vecs[4]  = '{mk(0,0, 0,0, 0,0, 0,0),                 rr(130,210,  0, 0, 0)};
        vecs[5]  = '{mk(0,0, 0,0, 0,0, 0,0),                 rr(130,210,  0, 0, 1)};
        vecs[6]  = '{mk(300,110, 320,100, 318,140, 340,120), rr(320,120, 40,40, 0)};
        vecs[7]  = '{mk(200,70, 220,60, 218,100, 240,80),    rr(295,110, 40,40, 0)};
        vecs[8]  = '{mk(400,110, 402,100, 401,140, 404,120), rr(321,112,  4,40, 0)};
        vecs[9]  = '{mk(400,110, 402,100, 401,140, 403,120), rr(321,112,  0, 0, 0)};
        vecs[10] = '{mk(500,110, 300,100, 300,140, 100,120), rr(321,112,  0, 0, 0)};
        vecs[11] = '{mk(320,110, 340,100, 338,140, 360,120), rr(325,114, 40,40, 0)};
        vecs[12] = '{mk(1000,110, 1010,100, 1005,140, 1020,120), rr(496,115, 20,40, 0)};
        vecs[13] = '{mk(1000,110, 1010,100, 1005,140, 1020,120), rr(624,116, 20,40, 0)};
        vecs[14] = '{mk(1000,110, 1010,100, 1005,140, 1020,120), rr(639,117, 20,40, 0)};
        vecs[15] = '{mk(634,110, 637,100, 636,140, 640,120), rr(638,117,  6,40, 0)};

        res_if.out_ready = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_out_valid", res_if.out_valid, 0);
        check("rst_target_lost", res_if.target_lost, 1);
        check("rst_center_x", res_if.center_x, 0);
        check("rst_center_y", res_if.center_y, 0);
        check("rst_span_x", res_if.span_x, 0);
        check("rst_span_y", res_if.span_y, 0);
        check("rst_overrun", res_if.frame_overrun, 0);
        check("rst_state", dbg.state, ST_IDLE);
        reset_n = 1'b1;
        res_if.out_ready = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Table: one frame per row, consumer always ready.
        for (int i = 0; i < NV; i++) begin
            exp_q.push_back(vecs[i].r);
            send_frame(vecs[i].c, 1'b0);
            wait_valid(lat);
            check("latency", lat, 4);
            @(negedge clk);
            check("valid_drop", res_if.out_valid, 0);
            check("idle_after_xfer", dbg.state, ST_IDLE);
        end

        // Asynchronous reset in the middle of a frame (E+2).
        send_frame(vecs[11].c, 1'b0);
        @(posedge clk); #2;
        check("pre_reset_state", dbg.state, ST_COMPUTE);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", res_if.out_valid, 0);
        check("midrst_target_lost", res_if.target_lost, 1);
        check("midrst_center_x", res_if.center_x, 0);
        check("midrst_span_y", res_if.span_y, 0);
        check("midrst_state", dbg.state, ST_IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_discarded", res_if.out_valid, 0);

        // Overrun: consumer stalls across two edges.
        f_a = vecs[0].c;
        f_b = vecs[1].c;
        d1 = rr(120,210, 40,60, 0);
        d2 = rr(130,210, 40,60, 0);
        res_if.out_ready = 1'b0;
        send_frame(f_a, 1'b0);
        wait_valid(lat);
        check("ovr_f1_latency", lat, 4);
        check("ovr_f1_center_x", res_if.center_x, d1.cx);
        check("ovr_f1_center_y", res_if.center_y, d1.cy);
        check("ovr_f1_span_y", res_if.span_y, d1.sy);
        check("ovr_f1_lost", res_if.target_lost, d1.lost);
        repeat (3) @(negedge clk);
        check("ovr_stall_valid", res_if.out_valid, 1);
        check("ovr_stall_center_x", res_if.center_x, d1.cx);
        exp_q.push_back(d2);
        send_frame(f_b, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("ovr_hold_valid", res_if.out_valid, 1);
            check("ovr_hold_center_x", res_if.center_x, d1.cx);
            check("ovr_hold_no_pulse", res_if.frame_overrun, 0);
        end
        @(negedge clk);
        check("ovr_pulse", res_if.frame_overrun, 1);
        check("ovr_new_center_x", res_if.center_x, d2.cx);
        check("ovr_state", dbg.state, ST_PRESENT);
        @(negedge clk);
        check("ovr_pulse_len", res_if.frame_overrun, 0);
        check("ovr_still_valid", res_if.out_valid, 1);
        @(posedge clk); #1;
        res_if.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("single_xfer_valid", res_if.out_valid, 0);
        check("single_xfer_queue", exp_q.size(), 0);
        @(posedge clk); #1;
        res_if.out_ready = 1'b0;

        // Transfer in the same cycle as the next edge: no overrun.
        d3 = rr(137,210, 40,60, 0);
        d4 = rr(142,210, 40,60, 0);
        exp_q.push_back(d3);
        send_frame(f_b, 1'b0);
        wait_valid(lat);
        check("same_f3_latency", lat, 4);
        repeat (2) @(negedge clk);
        exp_q.push_back(d4);
        send_frame(f_b, 1'b1);
        check("same_f3_taken", exp_q.size(), 1);
        wait_valid(lat);
        check("same_f4_latency", lat, 4);
        check("same_no_overrun", res_if.frame_overrun, 0);
        check("same_f4_center_x", res_if.center_x, d4.cx);
        @(posedge clk); #1;
        res_if.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        res_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("same_f4_done", res_if.out_valid, 0);

        // ---------------- report ----------------
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
